// File: rtl/serial_operand_tx_pkg.sv
// Types shared by the serial operand transmitter, the serial adder and the sum deserializer.
package serial_operand_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        SHIFT = 2'd2
    } tx_state_t;

endpackage

// File: rtl/serial_operand_tx_piso.sv
// Parallel-load, right-shift register; LSB is presented on o_bit.
module piso_shift_reg #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_bit
);

    logic [WIDTH-1:0] r_data;

    // Load wins over shift so a back-to-back burst replaces the spent word.
    always_ff @(posedge i_clk) begin
        if (i_rst)        r_data <= '0;
        else if (i_load)  r_data <= i_data;
        else if (i_shift) r_data <= {1'b0, r_data[WIDTH-1:1]};
    end

    assign o_bit = r_data[0];

endmodule

// File: rtl/serial_operand_tx.sv
// Serializes operand pairs LSB-first toward a serial adder, with a one-entry holding register
// so a new burst can follow the previous one without a gap cycle.
module serial_operand_tx
    import serial_operand_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_word_a,
    input  logic [DATA_WIDTH-1:0] i_word_b,
    input  logic                  i_word_valid,
    output logic                  o_word_ready,
    output logic                  o_din_a,
    output logic                  o_din_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy
);

    localparam int            CW   = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    tx_state_t             r_state;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_hold_a;
    logic [DATA_WIDTH-1:0] r_hold_b;
    logic                  r_hold_full;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_xfer;
    logic                  w_from_hold;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_a;
    logic [DATA_WIDTH-1:0] w_load_b;

    assign w_ready     = i_en && !i_rst && !r_hold_full;
    assign w_accept    = w_ready && i_word_valid;
    assign w_last      = i_en && (r_state == SHIFT) && (r_cnt == LAST);
    assign w_xfer      = i_en && ((r_state == SHIFT) || ((r_state == OFFER) && i_ready));
    assign w_from_hold = w_last && r_hold_full;
    // A fresh pair goes straight to the shifters when they are idle or finishing this cycle.
    assign w_load      = w_from_hold || (w_accept && ((r_state == IDLE) || w_last));
    assign w_load_a    = w_from_hold ? r_hold_a : i_word_a;
    assign w_load_b    = w_from_hold ? r_hold_b : i_word_b;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hold_a    <= '0;
            r_hold_b    <= '0;
            r_hold_full <= 1'b0;
        end else if (i_en) begin
            if (w_accept && !w_load) begin
                r_hold_a    <= i_word_a;
                r_hold_b    <= i_word_b;
                r_hold_full <= 1'b1;
            end else if (w_from_hold) begin
                r_hold_full <= 1'b0;
            end

            case (r_state)
                IDLE:  if (w_accept) r_state <= OFFER;
                OFFER: if (i_ready) begin
                    r_cnt   <= CW'(1);
                    r_state <= SHIFT;
                end
                SHIFT: if (w_last) begin
                    r_cnt   <= '0;
                    r_state <= (r_hold_full || w_accept) ? OFFER : IDLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    piso_shift_reg #(.WIDTH(DATA_WIDTH)) u_piso_a (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_shift (w_xfer),
        .i_data  (w_load_a),
        .o_bit   (o_din_a)
    );

    piso_shift_reg #(.WIDTH(DATA_WIDTH)) u_piso_b (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_shift (w_xfer),
        .i_data  (w_load_b),
        .o_bit   (o_din_b)
    );

    assign o_word_ready = w_ready;
    assign o_valid      = i_en && (r_state != IDLE);
    assign o_busy       = (r_state != IDLE) || r_hold_full;

endmodule
